// File: rtl/bit_feeder_pkg.sv
// Shared types and constants for the bit_feeder serialiser and its idle-pattern generator.
package bit_feeder_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam logic [6:0] PRBS7_SEED   = 7'h7F;
    localparam int         PRBS7_TAP_HI = 6;
    localparam int         PRBS7_TAP_LO = 5;

    // Feedback bit of x^7 + x^6 + 1; it is also the bit the generator emits.
    function automatic logic prbs7_fb(input logic [6:0] s);
        return s[PRBS7_TAP_HI] ^ s[PRBS7_TAP_LO];
    endfunction

endpackage

// File: rtl/bit_feeder_prbs7_gen.sv
// PRBS7 (x^7 + x^6 + 1) source that fills the serial line while the feeder is idle.
module prbs7_gen
    import bit_feeder_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic adv_i,
    output logic bit_o
);

    logic [6:0] lfsr_q;
    logic [6:0] lfsr_d;

    assign bit_o = prbs7_fb(lfsr_q);

    always_comb begin
        lfsr_d = lfsr_q;
        if (adv_i) begin
            lfsr_d = {lfsr_q[5:0], prbs7_fb(lfsr_q)};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_q <= PRBS7_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

endmodule

// File: rtl/bit_feeder.sv
// Parallel-to-serial feeder: one WIDTH-bit word in, one registered bit per cycle out.
// Define BIT_FEEDER_PRBS_EN to drive a PRBS7 pattern on x while idle (default: x=0 when idle).
module bit_feeder
    import bit_feeder_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             x,
    output logic             x_valid,
    output logic             busy,
    output logic             word_done
);

    localparam int            CW        = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST      = CW'(WIDTH - 1);
    localparam logic [CW-1:0] NEXT_LAST = CW'(WIDTH - 2);

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic             x_q, x_d;
    logic             x_valid_q, x_valid_d;
    logic             busy_q, busy_d;
    logic             word_done_q, word_done_d;
    logic             last_bit;
    logic             accept;
    logic             idle_bit;

    // Handshake: a word transfers on a rising edge with in_valid && in_ready;
    // in_ready depends on registered state only, so it never waits on in_valid.
    assign last_bit = (state_q == SHIFT) && (cnt_q == LAST);
    assign accept   = in_valid && in_ready;

`ifdef BIT_FEEDER_PRBS_EN
    logic prbs_adv;

    assign prbs_adv = (state_d == IDLE);

    prbs7_gen u_prbs (
        .clk   (clk),
        .rst   (rst),
        .adv_i (prbs_adv),
        .bit_o (idle_bit)
    );
`else
    assign idle_bit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            shreg_q     <= '0;
            x_q         <= 1'b0;
            x_valid_q   <= 1'b0;
            busy_q      <= 1'b0;
            word_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shreg_q     <= shreg_d;
            x_q         <= x_d;
            x_valid_q   <= x_valid_d;
            busy_q      <= busy_d;
            word_done_q <= word_done_d;
        end
    end

    // The first bit goes straight to x_q on accept, so shreg holds the remaining bits.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shreg_d = shreg_q;
        if (accept) begin
            state_d = SHIFT;
            cnt_d   = '0;
            shreg_d = MSB_FIRST ? (in_data << 1) : (in_data >> 1);
        end else if (state_q == SHIFT) begin
            if (last_bit) begin
                state_d = IDLE;
                cnt_d   = '0;
            end else begin
                cnt_d   = cnt_q + 1'b1;
                shreg_d = MSB_FIRST ? (shreg_q << 1) : (shreg_q >> 1);
            end
        end
    end

    always_comb begin
        in_ready    = (state_q == IDLE) || last_bit;
        x_d         = idle_bit;
        x_valid_d   = 1'b0;
        busy_d      = 1'b0;
        word_done_d = 1'b0;
        if (accept) begin
            x_d       = MSB_FIRST ? in_data[WIDTH-1] : in_data[0];
            x_valid_d = 1'b1;
            busy_d    = 1'b1;
        end else if ((state_q == SHIFT) && !last_bit) begin
            x_d         = MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0];
            x_valid_d   = 1'b1;
            busy_d      = 1'b1;
            word_done_d = (cnt_q == NEXT_LAST);
        end
    end

    assign x         = x_q;
    assign x_valid   = x_valid_q;
    assign busy      = busy_q;
    assign word_done = word_done_q;

endmodule

// File: tb/tb_bit_feeder.sv
// Bench for bit_feeder: LSB-first and MSB-first instances share one stimulus stream.
module tb_bit_feeder;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic [W-1:0] in_data;

    logic rdy_l, x_l, xv_l, busy_l, wd_l;
    logic rdy_m, x_m, xv_m, busy_m, wd_m;

    always #5 clk = ~clk;

    bit_feeder #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (rdy_l),
        .x         (x_l),
        .x_valid   (xv_l),
        .busy      (busy_l),
        .word_done (wd_l)
    );

    bit_feeder #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_msb (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (rdy_m),
        .x         (x_m),
        .x_valid   (xv_m),
        .busy      (busy_m),
        .word_done (wd_m)
    );

    // Each entry is {expected x, expected word_done} for one payload cycle.
    logic [1:0] exp_q[2][$];
    int n_cmp = 0;
    int n_bad = 0;
    int wd_seen[2];
    int words_exp = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic mon(input int k, input string nm, input logic xv, input logic xx,
                       input logic wd, input logic bs, input logic rdy);
        logic [1:0] e;
        if (xv) begin
            if (exp_q[k].size() == 0) begin
                check({nm, ".spurious_valid"}, xv, 1'b0);
            end else begin
                e = exp_q[k].pop_front();
                check({nm, ".x"}, xx, e[1]);
                check({nm, ".word_done"}, wd, e[0]);
                check({nm, ".busy"}, bs, 1'b1);
                check({nm, ".in_ready"}, rdy, e[0]);
            end
        end else begin
            check({nm, ".idle_word_done"}, wd, 1'b0);
            check({nm, ".idle_busy"}, bs, 1'b0);
            check({nm, ".idle_x"}, xx, 1'b0);
            if (exp_q[k].size() != 0) check({nm, ".gap"}, xv, 1'b1);
        end
        if (wd) wd_seen[k]++;
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            mon(0, "lsb", xv_l, x_l, wd_l, busy_l, rdy_l);
            mon(1, "msb", xv_m, x_m, wd_m, busy_m, rdy_m);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Holds in_valid until the accepting edge; leaves in_valid high on return.
    task automatic offer(input logic [W-1:0] d);
        int budget;
        budget   = 0;
        in_data  = d;
        in_valid = 1'b1;
        while (!rdy_l && budget < 50) begin
            tick();
            budget++;
        end
        if (!rdy_l) begin
            check("ready_timeout", rdy_l, 1'b1);
        end else begin
            tick();
            for (int i = 0; i < W; i++) begin
                exp_q[0].push_back({d[i], (i == W - 1)});
                exp_q[1].push_back({d[W-1-i], (i == W - 1)});
            end
            words_exp++;
        end
    endtask

    task automatic drain();
        int budget;
        budget = 0;
        while ((exp_q[0].size() != 0 || exp_q[1].size() != 0) && budget < 100) begin
            tick();
            budget++;
        end
        check("drain_lsb", exp_q[0].size(), 0);
        check("drain_msb", exp_q[1].size(), 0);
    endtask

    initial begin
        wd_seen[0] = 0;
        wd_seen[1] = 0;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        repeat (3) tick();
        rst = 1'b0;

        check("rst_x", x_l, 1'b0);
        check("rst_x_valid", xv_l, 1'b0);
        check("rst_busy", busy_l, 1'b0);
        check("rst_word_done", wd_l, 1'b0);
        check("rst_in_ready", rdy_l, 1'b1);
        check("rst_msb_in_ready", rdy_m, 1'b1);

        offer(8'hA5);
        in_valid = 1'b0;
        drain();
        check("a5_busy_after", busy_l, 1'b0);
        check("a5_ready_after", rdy_l, 1'b1);

        offer(8'hFF);
        offer(8'h00);
        in_valid = 1'b0;
        drain();

        offer(8'h3C);
        in_valid = 1'b0;
        repeat (10) begin
            in_data = W'($urandom_range(0, 255));
            tick();
        end
        drain();

        offer(8'h0F);
        in_valid = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        exp_q[0].delete();
        exp_q[1].delete();
        words_exp--;
        tick();
        rst = 1'b0;
        check("abort_x", x_l, 1'b0);
        check("abort_x_valid", xv_l, 1'b0);
        check("abort_busy", busy_l, 1'b0);
        check("abort_in_ready", rdy_l, 1'b1);

        in_data  = 8'h81;
        in_valid = 1'b1;
        rst      = 1'b1;
        tick();
        rst      = 1'b0;
        in_valid = 1'b0;
        check("rst_drop_x_valid", xv_l, 1'b0);
        check("rst_drop_busy", busy_m, 1'b0);
        tick();
        check("rst_drop_x_valid_later", xv_m, 1'b0);

        repeat (6) begin
            offer(W'($urandom_range(0, 255)));
            if ($urandom_range(0, 1) == 0) in_valid = 1'b0;
            repeat ($urandom_range(0, 3)) tick();
        end
        in_valid = 1'b0;
        drain();
        tick();

        check("word_done_count_lsb", wd_seen[0], words_exp);
        check("word_done_count_msb", wd_seen[1], words_exp);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/bit_feeder.md
BIT_FEEDER -- requirements
Module: bit_feeder

Interface
REQ-001 Parameter WIDTH, default 8, sets the number of bits per word and SHALL be at least 2.
REQ-002 Parameter MSB_FIRST, default 0, selects serial order: 0 sends LSB first, 1 sends MSB first.
REQ-003 Port clk, input, 1 bit, is the single clock; all state SHALL update on its rising edge.
REQ-004 Port rst, input, 1 bit, is the synchronous active-high reset.
REQ-005 Port in_data, input, WIDTH bits, is the parallel word to serialise.
REQ-006 Port in_valid, input, 1 bit, signals that in_data holds a word to accept.
REQ-007 Port in_ready, output, 1 bit, signals that the block can accept a word this cycle.
REQ-008 Port x, output, 1 bit, is the serial bit that drives the downstream FSM input x.
REQ-009 Port x_valid, output, 1 bit, is high while x carries a payload bit.
REQ-010 Port busy, output, 1 bit, is high while a word is being shifted out.
REQ-011 Port word_done, output, 1 bit, pulses for one cycle with the last bit of each word.

Function
REQ-012 The state machine SHALL have two states, IDLE and SHIFT, with a bit counter of width clog2(WIDTH).
REQ-013 A word SHALL be accepted on a rising edge where in_valid and in_ready are both high.
REQ-014 In IDLE, in_ready SHALL be 1; an accept SHALL move to SHIFT, load the shift register and clear the counter.
REQ-015 x, x_valid, busy and word_done SHALL all be registered outputs, with no combinational path from any input.
REQ-016 The first bit of an accepted word SHALL appear on x in the cycle immediately after the accepting edge (latency 1).
REQ-017 In SHIFT, exactly one bit SHALL be presented per cycle for WIDTH consecutive cycles, with x_valid=1 and busy=1.
REQ-018 Bit order SHALL be in_data[0] up to in_data[WIDTH-1] when MSB_FIRST=0, and the reverse when MSB_FIRST=1.
REQ-019 in_ready SHALL be 0 in SHIFT except in the cycle presenting the last bit, where it SHALL be 1.
REQ-020 An accept during the last-bit cycle SHALL start the next word on the following cycle with no gap cycle.
REQ-021 Without such an accept, the block SHALL return to IDLE after the last bit.
REQ-022 word_done SHALL be 1 only in the cycle presenting bit WIDTH-1 of a word.
REQ-023 The counter SHALL wrap from WIDTH-1 to 0 on a back-to-back accept.
REQ-024 in_data SHALL be sampled only at the accepting edge; later changes to it SHALL have no effect on the word in flight.
REQ-025 In IDLE, x_valid, busy and word_done SHALL be 0, and x SHALL be as defined in REQ-029/REQ-030.

Reset
REQ-026 While rst=1 on an edge, the block SHALL enter IDLE and clear the counter and shift register; x, x_valid, busy and word_done SHALL be 0.
REQ-027 rst SHALL take priority over a simultaneous accept, and the offered word SHALL be dropped.
REQ-028 Reset asserted mid-word SHALL abort that word; no word_done SHALL be produced for it.

Configuration
REQ-029 With macro BIT_FEEDER_PRBS_EN defined, x in IDLE SHALL carry the next PRBS7 bit (x^7+x^6+1), seeded to 7'h7F by reset, advancing each IDLE cycle and holding during SHIFT.
REQ-030 Without BIT_FEEDER_PRBS_EN, x in IDLE SHALL be 0 and no PRBS logic SHALL be present.

Structure
REQ-031 Package bit_feeder_pkg SHALL hold the state typedef (IDLE, SHIFT), PRBS7_SEED = 7'h7F and the PRBS7 tap constants.
REQ-032 The PRBS generator SHALL be the sub-module prbs7_gen, instantiated only under BIT_FEEDER_PRBS_EN.

Verification
REQ-033 WIDTH=8, MSB_FIRST=0, accept 8'hA5 at edge N -> x = 1,0,1,0,0,1,0,1 in cycles N+1..N+8, x_valid=1 throughout, word_done=1 only at N+8, busy=0 at N+9.
REQ-034 MSB_FIRST=1, accept 8'hA5 -> x = 1,0,1,0,0,1,0,1 MSB first; in_ready=0 in cycles N+1..N+7 and 1 at N+8.
REQ-035 Back-to-back 8'hFF then 8'h00, in_valid held high -> 16 contiguous x_valid cycles with x = eight 1s then eight 0s, and two word_done pulses 8 cycles apart.
REQ-036 rst=1 at the 4th bit of 8'h0F -> next cycle x=0, x_valid=0, busy=0, in_ready=1, and no word_done for the aborted word.
REQ-037 in_data changed every cycle after accepting 8'h3C -> serial output is still 8'h3C.
REQ-038 BIT_FEEDER_PRBS_EN defined, idle for 127 cycles after reset -> x sequence repeats with period 127, with x_valid=0 throughout.
